// File: rtl/softex_addmul_issuer_if.sv
// softex_addmul_issuer_if.sv
//
// Shared types and the stream channel used by the add/mul FMA issuer.
//
// softex_addmul_issuer_pkg
//   operation_t : FMA operation select (OP_ADD / OP_MUL).
//
// softex_addmul_issuer_if
//   Parameters:
//     WIDTH      : FP element width in bits.
//     VECT_WIDTH : elements per beat.
//     TAG_WIDTH  : requester tag width.
//   Signals:
//     valid, ready : beat handshake.
//     vect         : VECT_WIDTH x WIDTH element vector.
//     strb         : per-element strobe.
//     tag          : requester tag.
//   Modports:
//     master : produces the beat (drives valid/vect/strb/tag, samples ready).
//     slave  : consumes the beat (samples valid/vect/strb/tag, drives ready).
//
// The issuer is a slave on both requester streams (ADD, MUL) and a master
// on both FMA input channels (add, mul).

package softex_addmul_issuer_pkg;
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } operation_t;
endpackage

interface softex_addmul_issuer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned VECT_WIDTH = 1,
  parameter int unsigned TAG_WIDTH  = 1
);
  logic                                valid;
  logic                                ready;
  logic [VECT_WIDTH-1:0][WIDTH-1:0]    vect;
  logic [VECT_WIDTH-1:0]               strb;
  logic [TAG_WIDTH-1:0]                tag;

  modport master (
    output valid,
    output vect,
    output strb,
    output tag,
    input  ready
  );

  modport slave (
    input  valid,
    input  vect,
    input  strb,
    input  tag,
    output ready
  );
endinterface

// File: rtl/softex_addmul_issuer.sv
// softex_addmul_issuer.sv
//
// Initiator-side issuer for the shared add/mul vector FMA. Arbitrates between
// the ADD and MUL requester streams, drives the FMA operation select and the
// per-channel beats, holds the two scalar operands, and bounds the number of
// beats outstanding inside the FMA with a completion-fed counter.
//
// Optional feature macro: SOFTEX_ADDMUL_ISSUER_RR_EN
//   defined   : round-robin arbitration in IDLE (pointer flips after each issue)
//   undefined : fixed priority, MUL over ADD; no pointer register
//
// Parameters:
//   WIDTH        : FP element width (must match the interface instances)
//   MAX_INFLIGHT : max beats outstanding in the FMA (>= 1)
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   clear_i               : synchronous soft clear
//   add/mul_scal_wr_i     : scalar write strobes
//   add/mul_scal_wdata_i  : scalar write data
//   scal_wr_ready_o       : scalar writes accepted this cycle
//   a_if, m_if            : ADD / MUL requester streams (slave)
//   add_if, mul_if        : FMA add / mul input channels (master)
//   operation_o           : ADD/MUL select to the FMA
//   add/mul_scal_valid_o  : scalar valid flags
//   add/mul_scal_o        : held scalars
//   done_i                : one result beat retired by the FMA
//   inflight_o            : registered outstanding-beat count
//   idle_o                : IDLE, nothing in flight, no requester valid

module softex_addmul_issuer
  import softex_addmul_issuer_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,

  input  logic                                add_scal_wr_i,
  input  logic                                mul_scal_wr_i,
  input  logic [WIDTH-1:0]                    add_scal_wdata_i,
  input  logic [WIDTH-1:0]                    mul_scal_wdata_i,
  output logic                                scal_wr_ready_o,

  softex_addmul_issuer_if.slave               a_if,
  softex_addmul_issuer_if.slave               m_if,
  softex_addmul_issuer_if.master              add_if,
  softex_addmul_issuer_if.master              mul_if,

  output operation_t                          operation_o,
  output logic                                add_scal_valid_o,
  output logic                                mul_scal_valid_o,
  output logic [WIDTH-1:0]                    add_scal_o,
  output logic [WIDTH-1:0]                    mul_scal_o,

  input  logic                                done_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
  output logic                                idle_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_ADD = 2'd1,
    HOLD_MUL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   add_scal_q, add_scal_d;
  logic [WIDTH-1:0]   mul_scal_q, mul_scal_d;
  logic               add_scal_valid_q, add_scal_valid_d;
  logic               mul_scal_valid_q, mul_scal_valid_d;

  logic               cap_ok;
  logic               add_elig;
  logic               mul_elig;
  logic               grant_add;
  logic               grant_mul;
  logic               issue;
  operation_t         operation;
  logic               scal_wr_ready;

`ifdef SOFTEX_ADDMUL_ISSUER_RR_EN
  operation_t         rr_ptr_q, rr_ptr_d;
`endif

  // Room for one more beat, either because the pipeline is not full or
  // because a beat retires in the same cycle and frees its slot.
  assign cap_ok = (cnt_q < MAX_CNT) || done_i;

  // Grants are suppressed during clear so that no beat enters the FMA in a
  // cycle whose counter update is discarded by the clear.
  assign add_elig = a_if.valid && add_scal_valid_q && cap_ok && !clear_i;
  assign mul_elig = m_if.valid && mul_scal_valid_q && cap_ok && !clear_i;

  // Arbitration and FSM next state. In HOLD the granted op is frozen and the
  // other requester is ignored until the held beat is accepted.
  always_comb begin
    grant_add = 1'b0;
    grant_mul = 1'b0;
    operation = OP_ADD;
    state_d   = state_q;

    case (state_q)
      IDLE: begin
`ifdef SOFTEX_ADDMUL_ISSUER_RR_EN
        if (add_elig && mul_elig) begin
          grant_add = (rr_ptr_q == OP_ADD);
          grant_mul = (rr_ptr_q == OP_MUL);
        end else begin
          grant_add = add_elig;
          grant_mul = mul_elig;
        end
`else
        grant_mul = mul_elig;
        grant_add = add_elig && !mul_elig;
`endif
        operation = grant_mul ? OP_MUL : OP_ADD;
      end
      HOLD_ADD: begin
        grant_add = a_if.valid && !clear_i;
        operation = OP_ADD;
      end
      HOLD_MUL: begin
        grant_mul = m_if.valid && !clear_i;
        operation = OP_MUL;
      end
      default: begin
        operation = OP_ADD;
      end
    endcase

    issue = (grant_add && add_if.ready) || (grant_mul && mul_if.ready);

    case (state_q)
      IDLE: begin
        if (grant_add && !add_if.ready) begin
          state_d = HOLD_ADD;
        end else if (grant_mul && !mul_if.ready) begin
          state_d = HOLD_MUL;
        end
      end
      HOLD_ADD, HOLD_MUL: begin
        if (issue) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // Outstanding-beat counter. A done_i with nothing outstanding is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && !(done_i && (cnt_q != '0))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!issue && done_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  // Scalars may only change when the FMA holds no beat that could still be
  // using them and nothing enters it this cycle.
  assign scal_wr_ready = (state_q == IDLE) && (cnt_q == '0) && !issue;

  always_comb begin
    add_scal_d       = add_scal_q;
    mul_scal_d       = mul_scal_q;
    add_scal_valid_d = add_scal_valid_q;
    mul_scal_valid_d = mul_scal_valid_q;
    if (scal_wr_ready && add_scal_wr_i) begin
      add_scal_d       = add_scal_wdata_i;
      add_scal_valid_d = 1'b1;
    end
    if (scal_wr_ready && mul_scal_wr_i) begin
      mul_scal_d       = mul_scal_wdata_i;
      mul_scal_valid_d = 1'b1;
    end
    if (clear_i) begin
      add_scal_valid_d = 1'b0;
      mul_scal_valid_d = 1'b0;
    end
  end

`ifdef SOFTEX_ADDMUL_ISSUER_RR_EN
  // The pointer names the op that wins the next tie: the one not just issued.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (operation == OP_ADD) ? OP_MUL : OP_ADD;
    end
    if (clear_i) begin
      rr_ptr_d = OP_ADD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= OP_ADD;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      add_scal_q       <= '0;
      mul_scal_q       <= '0;
      add_scal_valid_q <= 1'b0;
      mul_scal_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      add_scal_q       <= add_scal_d;
      mul_scal_q       <= mul_scal_d;
      add_scal_valid_q <= add_scal_valid_d;
      mul_scal_valid_q <= mul_scal_valid_d;
    end
  end

  // FMA channels: data is forwarded unconditionally, valid only when granted.
  assign add_if.valid = grant_add;
  assign add_if.vect  = a_if.vect;
  assign add_if.strb  = a_if.strb;
  assign add_if.tag   = a_if.tag;

  assign mul_if.valid = grant_mul;
  assign mul_if.vect  = m_if.vect;
  assign mul_if.strb  = m_if.strb;
  assign mul_if.tag   = m_if.tag;

  assign a_if.ready = grant_add && add_if.ready;
  assign m_if.ready = grant_mul && mul_if.ready;

  assign operation_o      = operation;
  assign scal_wr_ready_o  = scal_wr_ready;
  assign add_scal_o       = add_scal_q;
  assign mul_scal_o       = mul_scal_q;
  assign add_scal_valid_o = add_scal_valid_q;
  assign mul_scal_valid_o = mul_scal_valid_q;
  assign inflight_o       = cnt_q;
  assign idle_o           = (state_q == IDLE) && (cnt_q == '0) &&
                            !a_if.valid && !m_if.valid;

endmodule
